// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the mem_responder slice
//
// Purpose: FSM state encoding, default bus widths and the wait-counter width
// used by mem_responder and mem_array.
// Contents:
//    MEM_ADDR_W  default address width (256 words)
//    MEM_DATA_W  default word width
//    CNT_W       wait-state counter width (WAIT_STATES range 0..15)
//    state_e     responder FSM states
package mem_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 16;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word RAM with registered, holding read port
//
// Purpose: storage for mem_responder. One address port shared by reads and
// writes; the caller guarantees we and re are never high together.
// Ports:
//    clk    in   system clock
//    rst    in   synchronous active-high reset; clears only the read register
//    we     in   write strobe, mem[addr] <= wdata
//    re     in   read strobe, rdata <= mem[addr]
//    addr   in   word address
//    wdata  in   write data
//    rdata  out  last read result; held while re is low
module mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [0:DEPTH-1];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[addr];
      end
   end

   // Array contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MBR memory responder with wait states and loader
//
// Purpose: accepts one CPU read/write at a time, inserts WAIT_STATES wait
// cycles, then pulses mem_ready for one cycle. A side-band loader writes the
// array whenever the responder is idle and has priority over a new request.
// Optional feature: define MEM_WPROT_EN to drop CPU writes to addresses
// 0..PROTECT_TOP and raise the sticky mem_err flag.
// Ports:
//    clk        in   system clock
//    rst        in   synchronous active-high reset
//    mem_addr   in   CPU address
//    mem_wdata  in   CPU write data
//    mem_rd     in   read request (held until mem_ready)
//    mem_wr     in   write request (wins over mem_rd)
//    mem_rdata  out  last read result
//    mem_ready  out  one-cycle completion pulse
//    mem_busy   out  request in flight
//    load_en    in   loader write strobe
//    load_addr  in   loader address
//    load_data  in   loader data
//    mem_err    out  sticky protection violation (0 without MEM_WPROT_EN)
module mem_responder
   import mem_pkg::*;
#(
   parameter int                ADDR_W      = MEM_ADDR_W,
   parameter int                DATA_W      = MEM_DATA_W,
   parameter int                WAIT_STATES = 0,
   parameter logic [ADDR_W-1:0] PROTECT_TOP = 'h0F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rd,
   input  logic              mem_wr,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ready,
   output logic              mem_busy,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data,
   output logic              mem_err
);

   localparam int                WS_M1    = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WS_M1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;

   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;

`ifdef MEM_WPROT_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_d      = wr_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
`ifdef MEM_WPROT_EN
      err_d     = err_q;
`endif

      case (state_q)
         IDLE: begin
            if (load_en) begin
               ram_we    = 1'b1;
               ram_addr  = load_addr;
               ram_wdata = load_data;
            end else if (mem_rd || mem_wr) begin
               addr_d  = mem_addr;
               wdata_d = mem_wdata;
               wr_d    = mem_wr;
               if (WAIT_STATES == 0) begin
                  // No wait cycles: the read must launch on the accepting
                  // edge itself, straight from the request address.
                  state_d  = RESP;
                  ram_re   = ~mem_wr;
                  ram_addr = mem_addr;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end

         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               ram_re  = ~wr_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         RESP: begin
            state_d = IDLE;
            if (wr_q) begin
`ifdef MEM_WPROT_EN
               if (addr_q <= PROTECT_TOP) begin
                  err_d = 1'b1;
               end else begin
                  ram_we = 1'b1;
               end
`else
               ram_we = 1'b1;
`endif
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Reset aborts everything, including a write about to commit.
      if (rst) begin
         ram_we = 1'b0;
         ram_re = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
   end

`ifdef MEM_WPROT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign mem_err = err_q;
`else
   logic unused_protect_top;
   assign unused_protect_top = ^PROTECT_TOP;
   assign mem_err            = 1'b0;
`endif

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_array (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (mem_rdata)
   );

   // A reset arriving during RESP suppresses the pulse.
   assign mem_ready = (state_q == RESP) && !rst;
   assign mem_busy  = (state_q != IDLE);

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's MAR/MBR bus: 256 x 16 single-port word memory.
- Accepts one read or write request at a time and inserts a configurable number of wait states.
- Returns read data and a one-cycle ready pulse.
- A side-band loader port preloads program/data words before or between CPU accesses.

Parameters:
- ADDR_W, 8, address width (depth = 2**ADDR_W words)
- DATA_W, 16, word width
- WAIT_STATES, 0, extra cycles between accept and response; legal range 0..15
- PROTECT_TOP, 8'h0F, highest write-protected address; used only with MEM_WPROT_EN

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mem_addr  in  ADDR_W  address from CPU MAR
- mem_wdata  in  DATA_W  write data from CPU MBR
- mem_rd  in  1  read request
- mem_wr  in  1  write request
- mem_rdata  out  DATA_W  read data to CPU MBR
- mem_ready  out  1  one-cycle completion pulse, for reads and writes
- mem_busy  out  1  high while a request is in flight (WAIT or RESP)
- load_en  in  1  loader write strobe
- load_addr  in  ADDR_W  loader address
- load_data  in  DATA_W  loader data
- mem_err  out  1  sticky protection-violation flag; constant 0 without MEM_WPROT_EN

Behaviour:
- Clock and reset: one clock domain, clk; rst is synchronous and active-high.
- Reset values: state=IDLE, wait counter=0, mem_rdata=0, mem_ready=0, mem_busy=0, mem_err=0. Array contents are not cleared by rst.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If load_en=1: array[load_addr]<=load_data. No request is accepted that cycle; the loader wins the collision.
  - Otherwise, if mem_rd or mem_wr is high: latch addr, wdata and op, and accept. mem_wr=mem_rd=1 is treated as a write.
  - After accept: if WAIT_STATES=0, go to RESP; otherwise load counter=WAIT_STATES-1 and go to WAIT.
- WAIT: decrement counter; go to RESP when counter=0. Inputs, including load_en, are ignored.
- RESP:
  - mem_ready=1 for exactly this cycle.
  - Read: mem_rdata is updated on the edge entering RESP, so data is valid while mem_ready=1.
  - Write: array[latched addr]<=latched wdata on the edge leaving RESP.
  - Always returns to IDLE; no back-to-back acceptance from RESP.
- Latency: mem_ready rises WAIT_STATES+1 cycles after the accepting edge. Minimum request period is WAIT_STATES+2 cycles.
- Requester rule: hold mem_rd/mem_wr until mem_ready is seen, then drop it for at least one cycle. The block uses only the latched values.
- mem_rdata holds the last read result; writes and loads never change it.
- Write-then-read to the same address returns the new data; the write commits before the next accept is possible.
- Reset mid-operation (WAIT or RESP): returns to IDLE, no ready pulse, and a pending write is not committed.
- Address arithmetic: no wrap logic needed. Addresses are ADDR_W bits and all 256 locations are valid.

Optional Feature:
- Macro: MEM_WPROT_EN.
- Defined:
  - A CPU write with latched addr<=PROTECT_TOP still completes its handshake (mem_ready pulses) but leaves the array unchanged.
  - mem_err is set and stays at 1 until rst.
  - Loader writes ignore protection.
- Undefined: no protection logic; mem_err tied to 0.

Decomposition:
- Package mem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - default ADDR_W/DATA_W constants
  - wait-counter width constant (4)
- Sub-module mem_array: single-port synchronous RAM, one write port (muxed between loader and committed CPU write) and registered read. Optional $readmemh init for simulation.
- The FSM stays in mem_responder.

Test Plan:
- Reset/idle: assert rst 2 cycles -> mem_ready=0, mem_busy=0, mem_rdata=16'h0000, mem_err=0.
- Load then read (WAIT_STATES=0): load 8'h20<=16'hBEEF; mem_rd at 8'h20 -> mem_ready exactly 1 cycle after accept, mem_rdata=16'hBEEF.
- Write/read with WAIT_STATES=3: mem_wr 8'h40<=16'h1234, then mem_rd 8'h40 -> each mem_ready 4 cycles after accept, read returns 16'h1234, mem_busy high 4 cycles per op.
- Loader collision: load_en with mem_rd held in IDLE -> load committed; read accepted next cycle with ready delayed by 1; mem_rd+mem_wr both high -> write performed.
- Reset mid-WAIT: WAIT_STATES=5, mem_wr 8'h50<=16'hAAAA, rst at cycle 2 -> no mem_ready; later read of 8'h50 returns the prior value.
- MEM_WPROT_EN: mem_wr 8'h05<=16'hFFFF -> mem_ready pulses, array unchanged, mem_err=1 sticky; write 8'h10 succeeds.
